// File: rtl/dht11_sensor_model.sv
// dht11_sensor_model
//   Sensor side of the DHT11 single-wire bus. Waits for a long host low pulse,
//   answers with the response preamble, then shifts out a 40-bit frame
//   {rh_int, rh_dec, temp_int, temp_dec, cksum} MSB first. All protocol
//   timing counts i_tick pulses.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   i_tick         one-clk pulse every 10 us; the only timebase for the protocol
//   rh_int/rh_dec  humidity bytes, latched when a start pulse is accepted
//   temp_int/dec   temperature bytes, latched with the humidity bytes
//   corrupt_cksum  when set at latch time, the sent checksum has bit 0 flipped
//   busy           high from frame latch until the frame completes
//   done           one-clk pulse after the trailing low phase ends
//   state_led      current FSM state (IDLE=0 .. END_LOW=7)
//   dht11_io       open-drain bus pin: driven 0 or released, never driven 1
module dht11_sensor_model #(
  parameter int unsigned START_MIN_TICKS = 1800,
  parameter int unsigned HOST_REL_TICKS  = 4,
  parameter int unsigned RESP_LOW_TICKS  = 8,
  parameter int unsigned RESP_HIGH_TICKS = 8,
  parameter int unsigned BIT_LOW_TICKS   = 5,
  parameter int unsigned BIT0_HIGH_TICKS = 3,
  parameter int unsigned BIT1_HIGH_TICKS = 7,
  parameter int unsigned END_LOW_TICKS   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic [7:0] rh_int,
  input  logic [7:0] rh_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  input  logic       corrupt_cksum,
  output logic       busy,
  output logic       done,
  output logic [3:0] state_led,
  inout  logic       dht11_io
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DET_LOW   = 3'd1,
    WAIT_REL  = 3'd2,
    RESP_LOW  = 3'd3,
    RESP_HIGH = 3'd4,
    BIT_LOW   = 3'd5,
    BIT_HIGH  = 3'd6,
    END_LOW   = 3'd7
  } state_t;

  localparam logic [10:0] START_MIN = 11'(START_MIN_TICKS);
  localparam logic [10:0] HOST_REL  = 11'(HOST_REL_TICKS);
  localparam logic [10:0] RESP_LOW_N  = 11'(RESP_LOW_TICKS);
  localparam logic [10:0] RESP_HIGH_N = 11'(RESP_HIGH_TICKS);
  localparam logic [10:0] BIT_LOW_N   = 11'(BIT_LOW_TICKS);
  localparam logic [10:0] BIT0_HIGH_N = 11'(BIT0_HIGH_TICKS);
  localparam logic [10:0] BIT1_HIGH_N = 11'(BIT1_HIGH_TICKS);
  localparam logic [10:0] END_LOW_N   = 11'(END_LOW_TICKS);

  state_t      state, state_next;
  logic [10:0] cnt, cnt_next;
  logic [10:0] phase_len;
  logic        phase_end;
  logic [5:0]  bit_cnt, bit_next;
  logic [39:0] shift, shift_next;
  logic        busy_next, done_next;
  logic        drv_low, drv_next;
  logic        line_meta, line_sync;
  logic [7:0]  cksum;

  // Open-drain pin: only ever pulls low.
  assign dht11_io  = drv_low ? 1'b0 : 1'bz;
  assign state_led = {1'b0, state};

  // Synchronizer resets to the idle-high bus level so that leaving reset
  // never looks like a host start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_meta <= 1'b1;
      line_sync <= 1'b1;
    end else begin
      line_meta <= dht11_io;
      line_sync <= line_meta;
    end
  end

  always_comb begin
    cksum = (rh_int + rh_dec + temp_int + temp_dec) ^ {7'd0, corrupt_cksum};
  end

  // Length of the current timed phase; the bit high time depends on the
  // bit currently at the top of the shift register.
  always_comb begin
    phase_len = 11'd1;
    case (state)
      WAIT_REL:  phase_len = HOST_REL;
      RESP_LOW:  phase_len = RESP_LOW_N;
      RESP_HIGH: phase_len = RESP_HIGH_N;
      BIT_LOW:   phase_len = BIT_LOW_N;
      BIT_HIGH:  phase_len = shift[39] ? BIT1_HIGH_N : BIT0_HIGH_N;
      END_LOW:   phase_len = END_LOW_N;
      default:   phase_len = 11'd1;
    endcase
    phase_end = (cnt == phase_len - 11'd1);
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_cnt;
    shift_next = shift;
    busy_next  = busy;
    done_next  = 1'b0;
    if (i_tick) begin
      case (state)
        IDLE: begin
          if (!line_sync) begin
            cnt_next   = '0;
            state_next = DET_LOW;
          end
        end
        DET_LOW: begin
          if (!line_sync) begin
            if (cnt != '1) cnt_next = cnt + 11'd1;
          end else begin
            cnt_next = '0;
            if (cnt >= START_MIN) begin
              shift_next = {rh_int, rh_dec, temp_int, temp_dec, cksum};
              bit_next   = '0;
              busy_next  = 1'b1;
              state_next = WAIT_REL;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: begin
          if (!phase_end) begin
            cnt_next = cnt + 11'd1;
          end else begin
            cnt_next = '0;
            case (state)
              WAIT_REL:  state_next = RESP_LOW;
              RESP_LOW:  state_next = RESP_HIGH;
              RESP_HIGH: state_next = BIT_LOW;
              BIT_LOW:   state_next = BIT_HIGH;
              BIT_HIGH: begin
                shift_next = {shift[38:0], 1'b0};
                bit_next   = bit_cnt + 6'd1;
                state_next = (bit_cnt == 6'd39) ? END_LOW : BIT_LOW;
              end
              END_LOW: begin
                busy_next  = 1'b0;
                done_next  = 1'b1;
                state_next = IDLE;
              end
              default: state_next = state;
            endcase
          end
        end
      endcase
    end
    // Pin drive is a function of the state being entered, so it switches on
    // the same edge that consumes the terminal tick.
    drv_next = (state_next == RESP_LOW) || (state_next == BIT_LOW) ||
               (state_next == END_LOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      drv_low <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_cnt <= bit_next;
      shift   <= shift_next;
      busy    <= busy_next;
      done    <= done_next;
      drv_low <= drv_next;
    end
  end

endmodule
